// File: rtl/math_pkg.sv
// rtl/math_pkg.sv - shared fp32/fp64 constants, class enum and scalar helpers for the math log unit
package math_pkg;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_PINF = 32'h7F80_0000;
  localparam logic [31:0] FP32_NINF = 32'hFF80_0000;
  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
  localparam logic [63:0] FP64_QNAN = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] FP64_PINF = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] FP64_NINF = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] FP64_ONE  = 64'h3FF0_0000_0000_0000;

  typedef enum logic [2:0] {ZERO, SUBNORM, NORMAL, INF, QNAN, SNAN} fp_class_e;

  function automatic fp_class_e classify32(input logic [31:0] a);
    if (a[30:23] == 8'h00) return (a[22:0] == '0) ? ZERO : SUBNORM;
    if (a[30:23] == 8'hFF) return (a[22:0] == '0) ? INF : (a[22] ? QNAN : SNAN);
    return NORMAL;
  endfunction

  function automatic fp_class_e classify64(input logic [63:0] a);
    if (a[62:52] == 11'h000) return (a[51:0] == '0) ? ZERO : SUBNORM;
    if (a[62:52] == 11'h7FF) return (a[51:0] == '0) ? INF : (a[51] ? QNAN : SNAN);
    return NORMAL;
  endfunction

  // {invalid, divzero, inexact}; ln of any finite positive value other than 1.0 is irrational
  function automatic logic [2:0] log_flags(input fp_class_e c, input logic neg, input logic one);
    if (c == QNAN || (c == INF && !neg) || one) return 3'b000;
    if (c == SNAN || (neg && c != ZERO)) return 3'b100;
    if (c == ZERO) return 3'b010;
    return 3'b001;
  endfunction

  // Round-to-nearest-even of a binary64 pattern whose value is a normal binary32 number
  function automatic logic [31:0] narrow_f32(input logic [63:0] b);
    logic [7:0] exp8;
    logic       up;
    exp8 = 8'(b[62:52] - 11'd896);
    up   = b[28] & (b[29] | (|b[27:0]));
    return {b[63], {exp8, b[51:29]} + 31'(up)};
  endfunction

  function automatic logic [31:0] log32(input logic [31:0] a);
    fp_class_e   c;
    logic [23:0] m;
    int          e;
    real         v;
    c = classify32(a);
    if (c == QNAN || c == SNAN) return FP32_QNAN;
    if (c == ZERO) return FP32_NINF;
    if (a[31]) return FP32_QNAN;
    if (c == INF) return FP32_PINF;
    if (a == FP32_ONE) return 32'h0;
    // value = m * 2^e, built from an exact power-of-two double so subnormals widen losslessly
    m = {c == NORMAL, a[22:0]};
    e = (c == NORMAL) ? int'(a[30:23]) - 150 : -149;
    v = real'(m) * $bitstoreal({1'b0, 11'(e + 1023), 52'd0});
    return narrow_f32($realtobits($ln(v)));
  endfunction

  function automatic logic [63:0] log64(input logic [63:0] a);
    fp_class_e c;
    c = classify64(a);
    if (c == QNAN || c == SNAN) return FP64_QNAN;
    if (c == ZERO) return FP64_NINF;
    if (a[63]) return FP64_QNAN;
    if (c == INF) return FP64_PINF;
    if (a == FP64_ONE) return 64'h0;
    return $realtobits($ln($bitstoreal(a)));
  endfunction

endpackage

// File: rtl/math_pipe_stage.sv
// rtl/math_pipe_stage.sv - one elastic valid/ready register stage with bubble collapsing
module math_pipe_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign up_ready = !valid_q || dn_ready;
  assign dn_valid = valid_q;
  assign dn_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (up_ready) begin
      valid_q <= up_valid;
      data_q  <= up_data;
    end
  end

endmodule

// File: rtl/math_log.sv
// rtl/math_log.sv - pipelined elastic ln(a) for binary32/binary64; MATH_LOG_EXC_FLAGS_EN adds result_flags
module math_log
  import math_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result_data
`ifdef MATH_LOG_EXC_FLAGS_EN
  ,
  output logic [2:0]       result_flags
`endif
);

`ifdef MATH_LOG_EXC_FLAGS_EN
  localparam int PW = WIDTH + 3;
  logic [2:0] ln_flags;
`else
  localparam int PW = WIDTH;
`endif

  logic [WIDTH-1:0] ln_data;
  logic [PW-1:0]    entry;

  generate
    if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
      $fatal(1, "math_log: parameter WIDTH must be 32 or 64");
    end
    if (LATENCY < 1) begin : g_bad_latency
      $fatal(1, "math_log: parameter LATENCY must be >= 1");
    end

    if (WIDTH == 64) begin : g_f64
      assign ln_data = log64(a_data);
`ifdef MATH_LOG_EXC_FLAGS_EN
      assign ln_flags = log_flags(classify64(a_data), a_data[63], a_data == FP64_ONE);
`endif
    end else begin : g_f32
      assign ln_data = log32(a_data[31:0]);
`ifdef MATH_LOG_EXC_FLAGS_EN
      assign ln_flags = log_flags(classify32(a_data[31:0]), a_data[31], a_data[31:0] == FP32_ONE);
`endif
    end
  endgenerate

`ifdef MATH_LOG_EXC_FLAGS_EN
  assign entry = {ln_flags, ln_data};
`else
  assign entry = ln_data;
`endif

  // Index k is the upstream side of stage k; index LATENCY is the output port.
  logic          stg_valid [LATENCY+1];
  logic          stg_ready [LATENCY+1];
  logic [PW-1:0] stg_data  [LATENCY+1];

  assign stg_valid[0]       = a_valid;
  assign stg_data[0]        = entry;
  assign a_ready            = stg_ready[0];
  assign stg_ready[LATENCY] = result_ready;
  assign result_valid       = stg_valid[LATENCY];
  assign result_data        = stg_data[LATENCY][WIDTH-1:0];
`ifdef MATH_LOG_EXC_FLAGS_EN
  assign result_flags       = stg_data[LATENCY][WIDTH+:3];
`endif

  generate
    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
      math_pipe_stage #(.W(PW)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (stg_valid[k]),
        .up_ready (stg_ready[k]),
        .up_data  (stg_data[k]),
        .dn_valid (stg_valid[k+1]),
        .dn_ready (stg_ready[k+1]),
        .dn_data  (stg_data[k+1])
      );
    end
  endgenerate

endmodule

// File: tb/tb_math_log.sv
// tb/tb_math_log.sv - randomized self-checking bench for math_log against a real-arithmetic reference
module tb_math_log;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready, result_valid, result_ready;
  logic [31:0] a_data, result_data;
  logic        x_valid, x_ready, x_rvalid, x_rready;
  logic [63:0] x_data, x_rdata;
  logic [2:0]  result_flags, x_flags;

  always #5 clk = ~clk;

  math_log #(.WIDTH(32), .LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data)
`ifdef MATH_LOG_EXC_FLAGS_EN
    , .result_flags(result_flags)
`endif
  );

  math_log #(.WIDTH(64), .LATENCY(1)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(x_valid), .a_ready(x_ready), .a_data(x_data),
    .result_valid(x_rvalid), .result_ready(x_rready), .result_data(x_rdata)
`ifdef MATH_LOG_EXC_FLAGS_EN
    , .result_flags(x_flags)
`endif
  );

`ifndef MATH_LOG_EXC_FLAGS_EN
  assign result_flags = 3'b000;
  assign x_flags      = 3'b000;
`endif

  typedef struct {
    logic [31:0] d;
    int          tol;
    logic [2:0]  f;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp, input int tol = 0);
    logic [63:0] diff;
    n_checks++;
    diff = (got > exp) ? got - exp : exp - got;
    if (diff > 64'(tol)) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic real dec32(input logic [31:0] a);
    real frac;
    frac = real'(a[22:0]);
    if (a[30:23] == 8'd0) return frac * $pow(2.0, -149.0);
    return (1.0 + frac / 8388608.0) * $pow(2.0, real'(int'(a[30:23]) - 127));
  endfunction

  function automatic logic [31:0] enc32(input real x);
    real ax, sc;
    int  k, m;
    ax = (x < 0.0) ? -x : x;
    k  = $rtoi($floor($ln(ax) / $ln(2.0)));
    sc = ax / $pow(2.0, real'(k));
    if (sc >= 2.0) begin k++; sc = sc / 2.0; end
    if (sc < 1.0)  begin k--; sc = sc * 2.0; end
    m = $rtoi((sc - 1.0) * 8388608.0 + 0.5);
    if (m == 8388608) begin m = 0; k++; end
    return {x < 0.0, 8'(k + 127), 23'(m)};
  endfunction

  function automatic exp_t ref32(input logic [31:0] a);
    exp_t e;
    e.tol = 0;
    e.f   = 3'b000;
    if (a[30:23] == 8'hFF && a[22:0] != 0) begin
      e.d = 32'h7FC00000;
      e.f = a[22] ? 3'b000 : 3'b100;
    end else if (a[30:0] == 0) begin
      e.d = 32'hFF800000; e.f = 3'b010;
    end else if (a[31]) begin
      e.d = 32'h7FC00000; e.f = 3'b100;
    end else if (a[30:23] == 8'hFF) begin
      e.d = 32'h7F800000;
    end else if (a == 32'h3F800000) begin
      e.d = 32'h0;
    end else begin
      e.d = enc32($ln(dec32(a))); e.tol = 1; e.f = 3'b001;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen32();
    logic [31:0] sp [8] = '{32'h0, 32'h80000000, 32'hBF800000, 32'h7F800000,
                            32'h7FA00000, 32'h3F800000, 32'hFF800000, 32'h7FC00000};
    logic [31:0] w;
    int          sel;
    w   = $urandom;
    sel = $urandom_range(15, 0);
    case (sel)
      0:       return sp[$urandom_range(7, 0)];
      1:       return {9'b0, w[22:0]};
      2:       return 32'h3F7FFFF8 + 32'(w[3:0]);
      3, 4, 5, 6, 7, 8, 9: return {1'b0, w[30:0]};
      default: return w;
    endcase
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, " extra"}, 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " data"}, 64'(result_data), 64'(e.d), e.tol);
`ifdef MATH_LOG_EXC_FLAGS_EN
      check({tag, " flags"}, 64'(result_flags), 64'(e.f));
`endif
    end
  endtask

  // Called at a negedge with an idle pipe; returns at a negedge after the result is consumed.
  task automatic run32(input logic [31:0] a, output logic [31:0] r, output logic [2:0] f, output int lat);
    a_valid = 1'b1; a_data = a; result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0; lat = 1;
    while (!result_valid && lat < 50) begin @(negedge clk); lat++; end
    r = result_data; f = result_flags;
    @(negedge clk);
  endtask

  task automatic run64(input logic [63:0] a, output logic [63:0] r, output logic [2:0] f, output int lat);
    x_valid = 1'b1; x_data = a; x_rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    x_valid = 1'b0; lat = 1;
    while (!x_rvalid && lat < 50) begin @(negedge clk); lat++; end
    r = x_rdata; f = x_flags;
    @(negedge clk);
  endtask

  logic [31:0] dir_a [9] = '{32'h3F800000, 32'h402DF854, 32'h00000000, 32'h80000000, 32'hBF800000,
                             32'h7F800000, 32'h7FA00000, 32'hFF800000, 32'h7FC00000};
  logic [31:0] dir_r [9] = '{32'h00000000, 32'h3F800000, 32'hFF800000, 32'hFF800000, 32'h7FC00000,
                             32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000};
  logic [2:0]  dir_f [9] = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b100, 3'b000, 3'b100, 3'b100, 3'b000};
  logic [63:0] d64_a [4] = '{64'h3FF0000000000000, 64'h4000000000000000, 64'h0, 64'hBFF0000000000000};
  logic [63:0] d64_r [4] = '{64'h0, 64'h3FE62E42FEFA39EF, 64'hFFF0000000000000, 64'h7FF8000000000000};
  logic [2:0]  d64_f [4] = '{3'b000, 3'b001, 3'b010, 3'b100};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r32, held, cur;
    logic [63:0] r64;
    logic [2:0]  f;
    int          lat, sent, got, first_c, last_c, stale, cyc;
    logic [31:0] bp [6];

    a_valid = 0; a_data = 0; result_ready = 1;
    x_valid = 0; x_data = 0; x_rready = 1;
    rst_n = 1;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    a_valid = 1;
    #1;
    check("reset result_valid", 64'(result_valid), 64'd0);
    check("reset result_data", 64'(result_data), 64'd0);
    check("reset f64 result_valid", 64'(x_rvalid), 64'd0);
    a_valid = 0;
    rst_n = 1;
    #1 check("post-reset a_ready", 64'(a_ready), 64'd1);
    @(negedge clk);

    // Directed f32 values and special cases
    for (int i = 0; i < 9; i++) begin
      run32(dir_a[i], r32, f, lat);
      check($sformatf("f32 %h", dir_a[i]), 64'(r32), 64'(dir_r[i]), (i == 1) ? 1 : 0);
`ifdef MATH_LOG_EXC_FLAGS_EN
      check($sformatf("f32 flags %h", dir_a[i]), 64'(f), 64'(dir_f[i]));
`endif
      if (i == 0) check("f32 latency", 64'(lat), 64'd4);
    end

    // Directed f64 values, LATENCY=1
    for (int i = 0; i < 4; i++) begin
      run64(d64_a[i], r64, f, lat);
      check($sformatf("f64 %h", d64_a[i]), r64, d64_r[i], (i == 1) ? 1 : 0);
`ifdef MATH_LOG_EXC_FLAGS_EN
      check($sformatf("f64 flags %h", d64_a[i]), 64'(f), 64'(d64_f[i]));
`endif
      if (i == 0) check("f64 latency", 64'(lat), 64'd1);
    end

    // Backpressure: capacity of 4, then hold, then drain at full rate
    for (int i = 0; i < 6; i++) bp[i] = {2'b00, 30'($urandom)} | 32'h0080_0000;
    result_ready = 0; sent = 0;
    for (int c = 0; c < 10; c++) begin
      a_valid = (sent < 6);
      a_data  = bp[(sent < 6) ? sent : 0];
      #1;
      if (a_valid && a_ready) begin exp_q.push_back(ref32(a_data)); sent++; end
      @(negedge clk);
    end
    #1;
    check("bp accepted", 64'(sent), 64'd4);
    check("bp a_ready", 64'(a_ready), 64'd0);
    check("bp result_valid", 64'(result_valid), 64'd1);
    held = result_data;
    repeat (3) @(negedge clk);
    check("bp hold", 64'(result_data), 64'(held));
    result_ready = 1; got = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 30 && got < 6; c++) begin
      a_valid = (sent < 6);
      a_data  = bp[(sent < 6) ? sent : 0];
      #1;
      if (a_valid && a_ready) begin exp_q.push_back(ref32(a_data)); sent++; end
      if (result_valid) begin
        pop_check("bp");
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      @(negedge clk);
    end
    a_valid = 0;
    check("bp drained", 64'(got), 64'd6);
    check("bp rate", 64'(last_c - first_c), 64'd5);

    // Random valid/ready at 50%, 1000 items through the scoreboard
    sent = 0; got = 0; cyc = 0; cur = gen32();
    while (got < 1000 && cyc < 20000) begin
      a_valid      = (sent < 1000) && ($urandom_range(1, 0) == 1);
      a_data       = cur;
      result_ready = ($urandom_range(1, 0) == 1);
      #1;
      if (a_valid && a_ready) begin exp_q.push_back(ref32(cur)); sent++; cur = gen32(); end
      if (result_valid && result_ready) begin pop_check("rand"); got++; end
      @(negedge clk);
      cyc++;
    end
    a_valid = 0;
    check("rand count", 64'(got), 64'd1000);
    check("rand leftover", 64'(exp_q.size()), 64'd0);
    result_ready = 1;
    repeat (6) @(negedge clk);
    check("rand no duplicate", 64'(result_valid), 64'd0);

    // Reset with items in flight
    result_ready = 0;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1; a_data = gen32();
      @(negedge clk);
    end
    a_valid = 0;
    repeat (2) @(negedge clk);
    check("rst pre valid", 64'(result_valid), 64'd1);
    @(posedge clk);
    #3 rst_n = 0;
    a_valid = 1;
    #1;
    check("rst result_valid", 64'(result_valid), 64'd0);
    check("rst result_data", 64'(result_data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    a_valid = 0;
    rst_n = 1;
    #1 check("rst a_ready", 64'(a_ready), 64'd1);
    result_ready = 1; stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (result_valid) stale++;
    end
    check("rst stale", 64'(stale), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
